// File: rtl/wm8731_pkg.sv
// rtl/wm8731_pkg.sv - shared WM8731 codec types and constants
package wm8731_pkg;

   typedef enum logic [2:0] {
      s_IDLE,
      s_ADDR,
      s_ACK_ADDR,
      s_BYTE1,
      s_ACK1,
      s_BYTE2,
      s_ACK2,
      s_IGNORE
   } state_t;

   localparam logic [6:0] c_WM8731_DEV_ADDR  = 7'b0011010;
   localparam int         c_WM8731_NUM_REGS  = 11;
   localparam logic [6:0] c_WM8731_RESET_REG = 7'h0F;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers with edge and START/STOP detection
module i2c_bus_sync
   import wm8731_pkg::*;
(
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   // [0],[1] form the synchronizer, [2] holds the previous synchronized value
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], i_scl};
         sda_q <= {sda_q[1:0], i_sda};
      end
   end

   assign o_sda      = sda_q[1];
   assign o_scl_rise = scl_q[1] & ~scl_q[2];
   assign o_scl_fall = ~scl_q[1] & scl_q[2];
   assign o_start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
   assign o_stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/wm8731_i2c_target.sv
// rtl/wm8731_i2c_target.sv - write-only I2C target mirroring WM8731 control registers
module wm8731_i2c_target
   import wm8731_pkg::*;
#(
   parameter logic [6:0] p_DEV_ADDR = c_WM8731_DEV_ADDR,
   parameter int         p_NUM_REGS = c_WM8731_NUM_REGS
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_i2c_scl,
   inout  wire        io_i2c_sda,
   input  logic [6:0] i_rd_addr,
   output logic [8:0] o_rd_data,
   output logic [6:0] o_reg_addr,
   output logic [8:0] o_reg_data,
   output logic       o_wr_valid,
   output logic       o_busy
);

   localparam int         c_IDX_W    = (p_NUM_REGS > 1) ? $clog2(p_NUM_REGS) : 1;
   localparam logic [6:0] c_NUM_REGS = 7'(p_NUM_REGS);

   logic sda_in, scl_rise, scl_fall, start, stop;

   i2c_bus_sync u_sync (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_scl      (i_i2c_scl),
      .i_sda      (io_i2c_sda),
      .o_sda      (sda_in),
      .o_scl_rise (scl_rise),
      .o_scl_fall (scl_fall),
      .o_start    (start),
      .o_stop     (stop)
   );

   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       sda_oe_q, sda_oe_d;
   logic [6:0] reg_addr_q;
   logic       d8_q;
   logic       latch_addr, commit;
   logic [8:0] mirror [p_NUM_REGS];

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q    <= s_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         sda_oe_q   <= 1'b0;
         reg_addr_q <= '0;
         d8_q       <= 1'b0;
         o_reg_addr <= '0;
         o_reg_data <= '0;
         o_wr_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         sda_oe_q   <= sda_oe_d;
         o_wr_valid <= commit;
         if (latch_addr) begin
            reg_addr_q <= shift_q[7:1];
            d8_q       <= shift_q[0];
         end
         if (commit) begin
            o_reg_addr <= reg_addr_q;
            o_reg_data <= {d8_q, shift_q};
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      sda_oe_d   = sda_oe_q;
      latch_addr = 1'b0;
      commit     = 1'b0;
      if (start) begin
         state_d   = s_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else if (stop) begin
         state_d  = s_IDLE;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            s_ADDR, s_BYTE1, s_BYTE2: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = {shift_q[6:0], sda_in};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = '0;
                  if (state_q == s_ADDR) begin
                     // only a write to our own address is acknowledged
                     if (shift_q == {p_DEV_ADDR, 1'b0}) begin
                        state_d  = s_ACK_ADDR;
                        sda_oe_d = 1'b1;
                     end else begin
                        state_d = s_IGNORE;
                     end
                  end else if (state_q == s_BYTE1) begin
                     state_d    = s_ACK1;
                     sda_oe_d   = 1'b1;
                     latch_addr = 1'b1;
                  end else begin
                     state_d  = s_ACK2;
                     sda_oe_d = 1'b1;
                     commit   = 1'b1;
                  end
               end
            end
            s_ACK_ADDR, s_ACK1, s_ACK2: begin
               if (scl_fall) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
                  if (state_q == s_ACK_ADDR)  state_d = s_BYTE1;
                  else if (state_q == s_ACK1) state_d = s_BYTE2;
                  else                        state_d = s_IGNORE;
               end
            end
            default: ;
         endcase
      end
   end

   // codec reset register wipes the whole mirror instead of being stored
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         for (int i = 0; i < p_NUM_REGS; i++) mirror[i] <= '0;
      end else if (commit) begin
         if (reg_addr_q == c_WM8731_RESET_REG) begin
            for (int i = 0; i < p_NUM_REGS; i++) mirror[i] <= '0;
         end else if (reg_addr_q < c_NUM_REGS) begin
            mirror[reg_addr_q[c_IDX_W-1:0]] <= {d8_q, shift_q};
         end
      end
   end

   assign o_rd_data  = (i_rd_addr < c_NUM_REGS) ? mirror[i_rd_addr[c_IDX_W-1:0]] : 9'd0;
   assign o_busy     = (state_q != s_IDLE);
   assign io_i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_wm8731_i2c_target.sv
// tb/tb_wm8731_i2c_target.sv - randomized bench for wm8731_i2c_target against a transaction-level model
module tb_wm8731_i2c_target;

   localparam int         Q   = 8;
   localparam int         H   = 16;
   localparam logic [6:0] DEV = 7'b0011010;

   logic       clk = 1'b0;
   logic       i_rstn = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [6:0] rd_addr = '0;
   wire        sda_bus;
   logic [8:0] o_rd_data, o_reg_data;
   logic [6:0] o_reg_addr;
   logic       o_wr_valid, o_busy;

   assign sda_bus = sda_m ? 1'bz : 1'b0;
   pullup (sda_bus);

   always #5 clk = ~clk;

   wm8731_i2c_target dut (
      .i_clk      (clk),
      .i_rstn     (i_rstn),
      .i_i2c_scl  (scl_m),
      .io_i2c_sda (sda_bus),
      .i_rd_addr  (rd_addr),
      .o_rd_data  (o_rd_data),
      .o_reg_addr (o_reg_addr),
      .o_reg_data (o_reg_data),
      .o_wr_valid (o_wr_valid),
      .o_busy     (o_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0] mm [0:10];
   logic       model_busy = 1'b0;
   logic [6:0] exp_addr = '0;
   logic [8:0] exp_data = '0;
   int         exp_pulses = 0;
   int         dut_pulses = 0;
   int         drive_cycles = 0;
   logic       hold_chk = 1'b1;
   logic       wr_prev = 1'b0;
   logic [6:0] pend_addr;
   logic       pend_d8;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int model_rd(input logic [6:0] a);
      return (a < 7'd11) ? int'(mm[a[3:0]]) : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 11; i++) mm[i] = '0;
      model_busy = 1'b0;
      exp_addr   = '0;
      exp_data   = '0;
   endtask

   task automatic model_commit(input logic [6:0] a, input logic [8:0] d);
      exp_addr = a;
      exp_data = d;
      exp_pulses++;
      if (a == 7'h0F) begin
         for (int i = 0; i < 11; i++) mm[i] = '0;
      end else if (a < 7'd11) begin
         mm[a[3:0]] = d;
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // every-cycle comparison of DUT outputs against the model
   initial begin
      logic [6:0] r;
      forever begin
         @(negedge clk);
         if (!hold_chk) begin
            chk("busy", int'(o_busy), int'(model_busy));
            chk("reg_addr", int'(o_reg_addr), int'(exp_addr));
            chk("reg_data", int'(o_reg_data), int'(exp_data));
            chk("rd_data", int'(o_rd_data), model_rd(rd_addr));
         end
         chk("wr_valid_width", int'(o_wr_valid & wr_prev), 0);
         if (o_wr_valid) dut_pulses++;
         wr_prev = o_wr_valid;
         r = 7'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) r = 7'h7F;
         rd_addr = r;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sda_bus === 1'b0 && sda_m) drive_cycles++;
      end
   end

   task automatic do_reset();
      hold_chk = 1'b1;
      i_rstn = 1'b0;
      wait_n(3);
      model_reset();
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_wr_valid", int'(o_wr_valid), 0);
      chk("rst_reg_addr", int'(o_reg_addr), 0);
      chk("rst_reg_data", int'(o_reg_data), 0);
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_n(4);
      i_rstn = 1'b1;
      wait_n(1);
      hold_chk = 1'b0;
      wait_n(Q);
   endtask

   task automatic start_cond();
      hold_chk = 1'b1;
      sda_m = 1'b0;
      wait_n(Q);
      model_busy = 1'b1;
      wait_n(1);
      hold_chk = 1'b0;
      scl_m = 1'b0;
      wait_n(Q);
   endtask

   task automatic rep_start();
      sda_m = 1'b1;
      wait_n(Q);
      scl_m = 1'b1;
      wait_n(Q);
      start_cond();
   endtask

   task automatic stop_cond();
      sda_m = 1'b0;
      wait_n(Q);
      scl_m = 1'b1;
      wait_n(Q);
      hold_chk = 1'b1;
      sda_m = 1'b1;
      wait_n(Q);
      model_busy = 1'b0;
      wait_n(1);
      hold_chk = 1'b0;
      wait_n(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit commit_here, input int rst_bit,
                            output bit ack, output bit aborted);
      aborted = 1'b0;
      ack = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == rst_bit) begin
            do_reset();
            aborted = 1'b1;
            return;
         end
         sda_m = b[7-k];
         wait_n(Q);
         scl_m = 1'b1;
         wait_n(H);
         if (k == 7 && commit_here) hold_chk = 1'b1;
         scl_m = 1'b0;
         wait_n(Q);
         if (k == 7 && commit_here) begin
            model_commit(pend_addr, {pend_d8, b});
            wait_n(1);
            hold_chk = 1'b0;
         end
      end
      sda_m = 1'b1;
      wait_n(Q);
      scl_m = 1'b1;
      wait_n(H / 2);
      ack = (sda_bus === 1'b0);
      wait_n(H / 2);
      scl_m = 1'b0;
      wait_n(Q);
   endtask

   task automatic run_frame(input logic [7:0] b0, b1, b2, b3, input int nb,
                            input bit rs, input bit do_stop, input int rst_byte, input int rst_bit);
      bit addr_ok, ack, aborted, exp_ack;
      logic [7:0] bb;
      int drv0;
      drv0 = drive_cycles;
      if (rs) rep_start();
      else start_cond();
      addr_ok = (b0 == {DEV, 1'b0});
      for (int i = 0; i < nb; i++) begin
         bb = (i == 0) ? b0 : (i == 1) ? b1 : (i == 2) ? b2 : b3;
         exp_ack = (i == 0) ? addr_ok : (addr_ok && i <= 2);
         send_byte(bb, addr_ok && i == 2, (i == rst_byte) ? rst_bit : -1, ack, aborted);
         if (aborted) begin
            chk("pulses_after_reset", dut_pulses, exp_pulses);
            return;
         end
         chk($sformatf("ack_byte%0d", i), int'(ack), int'(exp_ack));
         if (i == 1) begin
            pend_addr = bb[7:1];
            pend_d8   = bb[0];
         end
      end
      if (do_stop) stop_cond();
      chk("pulses", dut_pulses, exp_pulses);
      if (!addr_ok) chk("sda_never_driven", drive_cycles - drv0, 0);
   endtask

   initial begin
      int   p0;
      bit   open;
      logic [7:0] b0, b1, b2, b3;
      logic [6:0] a;
      int   nb;
      bit   st;

      model_reset();
      i_rstn = 1'b0;
      wait_n(5);
      chk("init_busy", int'(o_busy), 0);
      chk("init_wr_valid", int'(o_wr_valid), 0);
      chk("init_reg_addr", int'(o_reg_addr), 0);
      chk("init_reg_data", int'(o_reg_data), 0);
      chk("init_sda_released", int'(sda_bus === 1'b1), 1);
      i_rstn = 1'b1;
      wait_n(2);
      hold_chk = 1'b0;
      wait_n(Q);

      // basic write to register 7
      p0 = dut_pulses;
      run_frame(8'h34, 8'h0E, 8'h42, 8'h00, 3, 0, 1, -1, -1);
      chk("w7_pulse_count", dut_pulses - p0, 1);
      chk("w7_reg_addr", int'(o_reg_addr), 7'h07);
      chk("w7_reg_data", int'(o_reg_data), 9'h042);
      chk("w7_model_mirror", int'(mm[7]), 9'h042);

      // wrong device address
      p0 = dut_pulses;
      run_frame(8'h36, 8'h0E, 8'h42, 8'h00, 3, 0, 1, -1, -1);
      chk("wrong_dev_no_pulse", dut_pulses - p0, 0);

      // read request is refused
      run_frame(8'h35, 8'hAA, 8'h00, 8'h00, 2, 0, 1, -1, -1);
      chk("read_busy_after_stop", int'(o_busy), 0);

      // preload the mirror, then codec reset via register 0x0F
      for (int r = 0; r < 11; r++) begin
         b2 = 8'($urandom);
         run_frame(8'h34, {7'(r), 1'b1}, b2, 8'h00, 3, 0, 1, -1, -1);
      end
      chk("preload_mirror10", int'(mm[10]), int'({1'b1, b2}));
      run_frame(8'h34, 8'h1E, 8'h00, 8'h00, 3, 0, 1, -1, -1);
      chk("creset_reg_addr", int'(o_reg_addr), 7'h0F);
      chk("creset_model_mirror3", int'(mm[3]), 0);

      // truncated frame, then a full write to register 0
      p0 = dut_pulses;
      run_frame(8'h34, 8'h0E, 8'h00, 8'h00, 2, 0, 1, -1, -1);
      chk("truncated_no_pulse", dut_pulses - p0, 0);
      run_frame(8'h34, 8'h01, 8'hFF, 8'h00, 3, 0, 1, -1, -1);
      chk("w0_reg_data", int'(o_reg_data), 9'h1FF);
      chk("w0_model_mirror", int'(mm[0]), 9'h1FF);

      // repeated start aborts the first frame
      p0 = dut_pulses;
      run_frame(8'h34, 8'h06, 8'h00, 8'h00, 2, 0, 0, -1, -1);
      run_frame(8'h34, 8'h07, 8'h55, 8'h00, 3, 1, 1, -1, -1);
      chk("rs_one_pulse", dut_pulses - p0, 1);
      chk("rs_reg_addr", int'(o_reg_addr), 7'h03);

      // reset during bit 4 of the second byte, then a normal frame
      p0 = dut_pulses;
      run_frame(8'h34, 8'h0E, 8'h42, 8'h00, 3, 0, 1, 1, 3);
      chk("midreset_no_pulse", dut_pulses - p0, 0);
      run_frame(8'h34, 8'h0B, 8'hAB, 8'h00, 3, 0, 1, -1, -1);
      chk("post_reset_reg_data", int'(o_reg_data), 9'h1AB);

      // randomized frames
      open = 1'b0;
      for (int f = 0; f < 30; f++) begin
         case ($urandom_range(0, 9))
            7:       b0 = 8'h36;
            8:       b0 = 8'h35;
            9:       b0 = 8'($urandom);
            default: b0 = 8'h34;
         endcase
         a  = 7'($urandom_range(0, 16));
         b1 = {a, 1'($urandom)};
         b2 = 8'($urandom);
         b3 = 8'($urandom);
         nb = $urandom_range(1, 4);
         st = (f == 29) || ($urandom_range(0, 3) != 0);
         run_frame(b0, b1, b2, b3, nb, open, st, -1, -1);
         open = !st;
      end

      wait_n(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wm8731_i2c_target.md
WM8731_I2C_TARGET -- requirements
Module: wm8731_i2c_target

Interface
REQ-001 Parameter p_DEV_ADDR, default 7'b0011010, is the 7-bit I2C device address this block answers to.
REQ-002 Parameter p_NUM_REGS, default 11, is the number of mirrored codec registers (addresses 0..p_NUM_REGS-1).
REQ-003 Port i_clk, input, 1: system clock.
REQ-004 Port i_rstn, input, 1: synchronous, active-low reset, sampled on i_clk.
REQ-005 Port i_i2c_scl, input, 1: I2C clock from the bus master; asynchronous to i_clk.
REQ-006 Port io_i2c_sda, inout, 1: I2C data; open-drain, driven only to 0 or released to Z.
REQ-007 Port i_rd_addr, input, 7: register mirror read address.
REQ-008 Port o_rd_data, output, 9: mirror contents at i_rd_addr; 9'd0 for out-of-range addresses.
REQ-009 Port o_reg_addr, output, 7: register address of the last committed write.
REQ-010 Port o_reg_data, output, 9: data of the last committed write.
REQ-011 Port o_wr_valid, output, 1: one-cycle pulse per committed write.
REQ-012 Port o_busy, output, 1: high from a detected START until the next detected STOP.

Function
REQ-013 SCL and SDA shall each pass through a 2-flop synchronizer, then a third flop for edge detection; i_clk shall be at least 16x the SCL frequency.
REQ-014 START shall be detected as a synchronized SDA fall while synchronized SCL is high; STOP as an SDA rise while SCL is high.
REQ-015 Data bits shall be sampled on synchronized SCL rising edges, MSB first.
REQ-016 FSM states: s_IDLE, s_ADDR, s_ACK_ADDR, s_BYTE1, s_ACK1, s_BYTE2, s_ACK2, s_IGNORE.
REQ-017 START from any state shall go to s_ADDR, clear the bit counter, and set o_busy; this includes a repeated START.
REQ-018 STOP from any state shall go to s_IDLE, release SDA and clear o_busy.
REQ-019 In s_ADDR, after 8 bits: if {byte[7:1]==p_DEV_ADDR, byte[0]==0}, go to s_ACK_ADDR; otherwise go to s_IGNORE with SDA released (NACK).
REQ-020 In each ACK state, SDA shall be driven low from the SCL falling edge after bit 8 until the following SCL falling edge; the FSM then advances (s_ACK_ADDR->s_BYTE1, s_ACK1->s_BYTE2, s_ACK2->s_IGNORE).
REQ-021 The address byte is {reg_addr[6:0], data[8]}; the data byte is data[7:0].
REQ-022 The write commits at the SCL falling edge that starts the ACK2 drive: o_reg_addr/o_reg_data update, o_wr_valid pulses for exactly 1 cycle, and the mirror is updated if reg_addr < p_NUM_REGS.
REQ-023 A commit with reg_addr==7'h0F (codec reset) shall clear every mirror entry to 9'd0 and shall still pulse o_wr_valid.
REQ-024 A reg_addr that is >= p_NUM_REGS and not 7'h0F shall be ACKed and pulse o_wr_valid, but leave the mirror unchanged.
REQ-025 In s_IGNORE, bytes after ACK2 shall be NACKed and ignored; no further commit occurs until a new START.
REQ-026 A STOP or repeated START before ACK2 shall abort the frame with no commit and no mirror change.
REQ-027 o_rd_data shall be combinational from the mirror; a read and a write to the same address in one cycle returns the old value.

Reset
REQ-028 While i_rstn==0: state=s_IDLE, SDA released, o_busy=0, o_wr_valid=0, o_reg_addr=0, o_reg_data=0, all mirror entries=0, synchronizers preset to 1.
REQ-029 A reset in mid-frame shall abort the frame; after release, the block ignores the bus until the next START.

Structure
REQ-030 The state_t enum, WM8731 default device address and register-count constants shall live in a shared package, wm8731_pkg, reused by the existing codec blocks.
REQ-031 Synchronization and START/STOP/edge detection shall be one sub-module, i2c_bus_sync, instantiated once.

Verification
REQ-032 Bytes 0x34,0x0E,0x42 followed by STOP -> 3 ACKs, one o_wr_valid pulse, o_reg_addr=7'h07, o_reg_data=9'h042, mirror[7]=9'h042.
REQ-033 Bytes 0x36,0x0E,0x42 -> NACK on the first byte, no pulse, mirror unchanged, SDA never driven.
REQ-034 Byte 0x35 (read) -> NACK, s_IGNORE until STOP, o_busy falls at STOP.
REQ-035 Mirror preloaded, then bytes 0x34,0x1E,0x00 -> pulse with o_reg_addr=7'h0F, all entries 0.
REQ-036 Bytes 0x34,0x0E then STOP -> no pulse; next full frame 0x34,0x01,0xFF -> mirror[0]=9'h1FF.
REQ-037 i_rstn asserted during bit 4 of byte 2 -> outputs at reset values, no commit; the next valid frame is accepted normally.
